data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_pkg.sv | 10 +
 rtl/data_mem_responder_mem_word_array.sv | 25 ++
 rtl/data_mem_responder.sv | 84 ++++++++
 tb/tb_data_mem_responder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared FSM encoding, opcode constants and fault-cause bit positions
package data_mem_responder_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam int F_MISALIGN = 0;
    localparam int F_RANGE    = 1;
    localparam int F_OP       = 2;
    localparam int F_W        = 3;
endpackage

// File: rtl/data_mem_responder_mem_word_array.sv
// mem_word_array: single-port word storage with registered, clearable read port
module mem_word_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic              clr_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    always_ff @(posedge clk)
        if (we_i) mem_q[idx_i] <= wdata_i;
    // clr_i forces a zero result for faulted accesses instead of leaking stored data
    always_ff @(posedge clk or posedge rst_i)
        if (rst_i) rdata_q <= '0;
        else if (re_i) rdata_q <= clr_i ? '0 : mem_q[idx_i];
    assign rdata_o = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency load/store responder with fault detection
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Ready,
    output logic              Err,
    output logic              Busy
);
    localparam int IDX_W = $clog2(DEPTH);
    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rd_q, wr_q, sample, commit, fault;
    logic [F_W-1:0]    cause_q, cause_d;
    always_comb begin
        cause_d             = '0;
        cause_d[F_MISALIGN] = Addr[1:0] != 2'b00;
        cause_d[F_RANGE]    = (Addr >> 2) >= ADDR_W'(DEPTH);
        cause_d[F_OP]       = MemRead & MemWrite;
    end
    assign sample = (state_q == IDLE) && (MemRead || MemWrite);
    assign commit = (state_q == WAIT) && (cnt_q == 4'd0);
    assign fault  = |cause_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:    if (sample) begin
                         state_d = WAIT;
                         cnt_d   = 4'(LATENCY - 1);
                     end
            WAIT:    if (commit) state_d = RESP;
                     else cnt_d = cnt_q - 4'd1;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (sample) begin
                idx_q   <= Addr[IDX_W+1:2];
                wdata_q <= WriteData;
                rd_q    <= MemRead;
                wr_q    <= MemWrite;
                cause_q <= cause_d;
            end
        end
    mem_word_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_mem (
        .clk    (clk),
        .rst_i  (reset),
        .we_i   (commit & wr_q & ~fault),
        .re_i   (commit & (rd_q | fault)),
        .clr_i  (fault),
        .idx_i  (idx_q),
        .wdata_i(wdata_q),
        .rdata_o(ReadData)
    );
    assign Ready = state_q == RESP;
    assign Busy  = state_q != IDLE;
    assign Err   = Ready & fault;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed + randomized checks of three latency variants against a word-array model
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        mr [3];
    logic        mw [3];
    logic [31:0] ad [3];
    logic [31:0] wd [3];
    logic [31:0] rdat [3];
    logic        rdy [3];
    logic        err [3];
    logic        busy [3];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mdl [3][256];
    bit          vld [3][256];
    logic [31:0] exp_rd [3];
    bit          known_rd [3];

    always #5 clk = ~clk;

    data_mem_responder #(.LATENCY(2)) dut0 (.clk(clk), .reset(reset), .MemRead(mr[0]), .MemWrite(mw[0]),
        .Addr(ad[0]), .WriteData(wd[0]), .ReadData(rdat[0]), .Ready(rdy[0]), .Err(err[0]), .Busy(busy[0]));
    data_mem_responder #(.LATENCY(1)) dut1 (.clk(clk), .reset(reset), .MemRead(mr[1]), .MemWrite(mw[1]),
        .Addr(ad[1]), .WriteData(wd[1]), .ReadData(rdat[1]), .Ready(rdy[1]), .Err(err[1]), .Busy(busy[1]));
    data_mem_responder #(.LATENCY(15)) dut15 (.clk(clk), .reset(reset), .MemRead(mr[2]), .MemWrite(mw[2]),
        .Addr(ad[2]), .WriteData(wd[2]), .ReadData(rdat[2]), .Ready(rdy[2]), .Err(err[2]), .Busy(busy[2]));

    function automatic int lat_of(int d);
        return d == 0 ? 2 : d == 1 ? 1 : 15;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(int d, bit perturb, output int n, output bit got);
        n   = 0;
        got = 0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (rdy[d]) got = 1;
            else begin
                chk($sformatf("busy_wait d%0d", d), 32'(busy[d]), 1);
                if (perturb) begin
                    ad[d] = $urandom;
                    wd[d] = $urandom;
                end
            end
        end
        chk($sformatf("ready_seen d%0d", d), 32'(got), 1);
    endtask

    task automatic check_resp(int d, logic [31:0] a, bit r, bit w, logic [31:0] wv, int n);
        bit f;
        int i;
        f = (a[1:0] != 2'b00) || (a >= 32'h400) || (r && w);
        i = int'(a[9:2]);
        chk($sformatf("latency d%0d a=%h", d, a), 32'(n - 1), 32'(lat_of(d)));
        chk($sformatf("busy_resp d%0d", d), 32'(busy[d]), 1);
        chk($sformatf("err d%0d a=%h r=%0d w=%0d", d, a, r, w), 32'(err[d]), 32'(f));
        if (f) begin
            exp_rd[d]   = '0;
            known_rd[d] = 1;
        end else if (w) begin
            mdl[d][i] = wv;
            vld[d][i] = 1;
        end else begin
            exp_rd[d]   = mdl[d][i];
            known_rd[d] = vld[d][i];
        end
        if (known_rd[d]) chk($sformatf("rdata d%0d a=%h", d, a), rdat[d], exp_rd[d]);
    endtask

    task automatic access(int d, bit r, bit w, logic [31:0] a, logic [31:0] wv, bit perturb);
        int n;
        bit got;
        @(negedge clk);
        mr[d] = r; mw[d] = w; ad[d] = a; wd[d] = wv;
        wait_ready(d, perturb, n, got);
        check_resp(d, a, r, w, wv, n);
        @(negedge clk);
        mr[d] = 0; mw[d] = 0;
        @(posedge clk); #1;
        chk($sformatf("ready_pulse d%0d", d), 32'(rdy[d]), 0);
        chk($sformatf("busy_drop d%0d", d), 32'(busy[d]), 0);
    endtask

    initial begin
        int n;
        bit got;
        logic [31:0] a;
        int k, o;
        reset = 1;
        for (int d = 0; d < 3; d++) begin
            mr[d] = 0; mw[d] = 0; ad[d] = 0; wd[d] = 0;
            exp_rd[d] = 0; known_rd[d] = 1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_rdata d%0d", d), rdat[d], 0);
            chk($sformatf("rst_ready d%0d", d), 32'(rdy[d]), 0);
            chk($sformatf("rst_err d%0d", d), 32'(err[d]), 0);
            chk($sformatf("rst_busy d%0d", d), 32'(busy[d]), 0);
        end
        @(negedge clk) reset = 0;

        access(0, 0, 1, 32'h8, 32'hA5A5_1234, 0);
        access(0, 1, 0, 32'h8, 0, 0);
        access(0, 0, 1, 32'h4, 32'h1111_2222, 0);
        access(0, 1, 0, 32'h6, 0, 0);
        access(0, 0, 1, 32'h5, 32'hFFFF_FFFF, 0);
        access(0, 1, 0, 32'h4, 0, 0);
        access(0, 0, 1, 32'h0, 32'h0000_0077, 0);
        access(0, 0, 1, 32'h400, 32'hCAFE_CAFE, 0);
        access(0, 1, 1, 32'h0, 32'h1234_5678, 0);
        access(0, 1, 0, 32'h0, 0, 0);

        // write held into an immediate read: RESP must not sample, the next edge does
        @(negedge clk);
        mw[0] = 1; ad[0] = 32'hC; wd[0] = 32'h11;
        wait_ready(0, 0, n, got);
        check_resp(0, 32'hC, 0, 1, 32'h11, n);
        @(negedge clk);
        mw[0] = 0; mr[0] = 1; ad[0] = 32'hC;
        @(posedge clk); #1;
        chk("b2b_no_sample_busy", 32'(busy[0]), 0);
        chk("b2b_no_sample_ready", 32'(rdy[0]), 0);
        @(posedge clk); #1;
        chk("b2b_sampled_busy", 32'(busy[0]), 1);
        ad[0] = 32'h20;
        wait_ready(0, 0, n, got);
        chk("b2b_latency", 32'(n), 32'(lat_of(0)));
        chk("b2b_rdata", rdat[0], 32'h11);
        chk("b2b_err", 32'(err[0]), 0);
        exp_rd[0] = 32'h11; known_rd[0] = 1;
        @(negedge clk) mr[0] = 0;
        @(posedge clk); #1;
        chk("b2b_idle", 32'(busy[0]), 0);

        // reset during WAIT must drop the pending write
        access(0, 0, 1, 32'h10, 32'h0BAD_F00D, 0);
        @(negedge clk);
        mw[0] = 1; ad[0] = 32'h10; wd[0] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        chk("midrst_busy_before", 32'(busy[0]), 1);
        @(negedge clk);
        reset = 1;
        #1;
        chk("midrst_busy", 32'(busy[0]), 0);
        chk("midrst_ready", 32'(rdy[0]), 0);
        chk("midrst_err", 32'(err[0]), 0);
        chk("midrst_rdata", rdat[0], 0);
        mw[0] = 0;
        for (int d = 0; d < 3; d++) begin
            exp_rd[d] = 0; known_rd[d] = 1;
        end
        @(posedge clk);
        @(negedge clk) reset = 0;
        access(0, 1, 0, 32'h10, 0, 0);

        access(1, 0, 1, 32'h3C, 32'h5555_AAAA, 0);
        access(1, 1, 0, 32'h3C, 0, 0);
        access(2, 0, 1, 32'h3C, 32'h1357_9BDF, 0);
        access(2, 1, 0, 32'h3C, 0, 0);
        access(2, 1, 0, 32'h2, 0, 0);

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 30; i++) begin
                k = int'($urandom_range(0, 9));
                a = k < 7 ? {26'd0, 4'($urandom_range(0, 15)), 2'b00}
                  : k == 7 ? ((32'($urandom) & 32'h3FC) | 32'($urandom_range(1, 3)))
                  : k == 8 ? 32'h400 + 32'($urandom_range(0, 1000)) * 4
                  : 32'($urandom);
                o = int'($urandom_range(0, 7));
                access(d, o == 0 || (o >= 1 && o <= 3), o == 0 || o >= 4, a, $urandom, 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
